// File: rtl/fpu_int2fp_round_pack.sv
// Int-to-float back end: normalise, round and pack in three pipelined stages.
// Optional NX flag generation is built when FPU_INT2FP_INEXACT_EN is defined.
module fpu_int2fp_round_pack #(
    parameter int MAG_W  = 64,
    parameter int BIAS_D = 1023,
    parameter int BIAS_S = 127
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAG_W-1:0] in_mag,
    input  logic             in_sign,
    input  logic             in_fmt,
    input  logic [2:0]       in_rm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_result,
    output logic [4:0]       out_fflags
);

    function automatic logic [5:0] lzc(input logic [MAG_W-1:0] v);
        logic [5:0] n;
        n = 6'd63;
        for (int i = 0; i < MAG_W; i++)
            if (v[i]) n = 6'(MAG_W - 1 - i);
        return n;
    endfunction

    logic        v1, v2, v3;
    logic        ld1, ld2, ld3;

    logic [63:0] norm1;
    logic [5:0]  lz1;
    logic        zero1, sign1, fmt1;
    logic [2:0]  rm1;

    logic [51:0] mant2;
    logic [10:0] exp2;
    logic        up2, sign2, fmt2;

    assign ld3       = !v3 || out_ready;
    assign ld2       = !v2 || ld3;
    assign ld1       = !v1 || ld2;
    assign in_ready  = ld1;
    assign out_valid = v3;

    // S1 inputs: leading-zero count and left-justified magnitude
    logic [5:0]  lz_in;
    logic        zero_in;

    always_comb begin
        lz_in   = lzc(in_mag);
        zero_in = (in_mag == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1    <= 1'b0;
            norm1 <= '0;
            lz1   <= '0;
            zero1 <= 1'b0;
            sign1 <= 1'b0;
            fmt1  <= 1'b0;
            rm1   <= '0;
        end else if (ld1) begin
            v1 <= in_valid;
            if (in_valid) begin
                norm1 <= 64'(in_mag) << lz_in;
                lz1   <= lz_in;
                zero1 <= zero_in;
                sign1 <= in_sign && !zero_in;
                fmt1  <= in_fmt;
                rm1   <= in_rm;
            end
        end
    end

    // S2 inputs: mantissa, guard/sticky, exponent and round decision
    logic [51:0] mant_c;
    logic        g_c, s_c, up_c;
    logic [10:0] bias_c, exp_c;

    always_comb begin
        mant_c = fmt1 ? norm1[62:11] : {29'b0, norm1[62:40]};
        g_c    = fmt1 ? norm1[10] : norm1[39];
        s_c    = fmt1 ? |norm1[9:0] : |norm1[38:0];
        bias_c = fmt1 ? 11'(BIAS_D) : 11'(BIAS_S);
        exp_c  = zero1 ? 11'd0 : bias_c + 11'd63 - {5'b0, lz1};
        case (rm1)
            3'b001:  up_c = 1'b0;
            3'b010:  up_c = sign1 && (g_c || s_c);
            3'b011:  up_c = !sign1 && (g_c || s_c);
            3'b100:  up_c = g_c;
            default: up_c = g_c && (s_c || mant_c[0]);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2    <= 1'b0;
            mant2 <= '0;
            exp2  <= '0;
            up2   <= 1'b0;
            sign2 <= 1'b0;
            fmt2  <= 1'b0;
        end else if (ld2) begin
            v2 <= v1;
            if (v1) begin
                mant2 <= mant_c;
                exp2  <= exp_c;
                up2   <= up_c;
                sign2 <= sign1;
                fmt2  <= fmt1;
            end
        end
    end

    // S3 inputs: mantissa increment with carry into the exponent
    logic [52:0] sum_d;
    logic [23:0] sum_s;
    logic        carry;
    logic [10:0] exp_r;
    logic [63:0] pack_c;

    always_comb begin
        sum_d  = {1'b0, mant2} + 53'(up2);
        sum_s  = {1'b0, mant2[22:0]} + 24'(up2);
        carry  = fmt2 ? sum_d[52] : sum_s[23];
        exp_r  = exp2 + 11'(carry);
        if (fmt2)
            pack_c = {sign2, exp_r, sum_d[51:0]};
        else
            pack_c = {32'hFFFF_FFFF, sign2, exp_r[7:0], sum_s[22:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3         <= 1'b0;
            out_result <= '0;
        end else if (ld3) begin
            v3 <= v2;
            if (v2)
                out_result <= pack_c;
        end
    end

`ifdef FPU_INT2FP_INEXACT_EN
    logic nx2, nx3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nx2 <= 1'b0;
        end else if (ld2 && v1) begin
            nx2 <= g_c || s_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nx3 <= 1'b0;
        end else if (ld3 && v2) begin
            nx3 <= nx2;
        end
    end

    assign out_fflags = {4'b0, nx3};
`else
    assign out_fflags = 5'b0;
`endif

endmodule

// File: tb/tb_fpu_int2fp_round_pack.sv
// Self-checking bench for fpu_int2fp_round_pack: directed literals,
// backpressure, mid-flight reset and randomized traffic vs. a reference model.
module tb_fpu_int2fp_round_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_mag;
    logic        in_sign;
    logic        in_fmt;
    logic [2:0]  in_rm;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_fflags;

    int compared = 0;
    int mismatched = 0;

    logic [68:0] sb[$];

`ifdef FPU_INT2FP_INEXACT_EN
    localparam bit NX_ON = 1'b1;
`else
    localparam bit NX_ON = 1'b0;
`endif

    fpu_int2fp_round_pack dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_mag(in_mag),
        .in_sign(in_sign),
        .in_fmt(in_fmt),
        .in_rm(in_rm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_result(out_result),
        .out_fflags(out_fflags)
    );

    always #5 clk = ~clk;

    // Reference: exact integer value, rounded to P significant bits.
    function automatic logic [68:0] model(input logic [63:0] mag,
                                          input logic sign,
                                          input logic fmt,
                                          input logic [2:0] rm);
        int p, prec, sh, e;
        logic [63:0] q, rem, half, r;
        logic up, nx;
        if (mag == 64'd0)
            return {(fmt ? 64'h0 : 64'hFFFF_FFFF_0000_0000), 5'b0};
        p = 0;
        for (int i = 0; i < 64; i++)
            if (mag[i]) p = i;
        prec = fmt ? 53 : 24;
        if (p < prec) begin
            q = mag << (prec - 1 - p);
            rem = 64'd0;
            half = 64'd0;
            sh = 0;
        end else begin
            sh = p - (prec - 1);
            q = mag >> sh;
            rem = mag & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
        end
        case (rm)
            3'd1: up = 1'b0;
            3'd2: up = sign && (rem != 0);
            3'd3: up = !sign && (rem != 0);
            3'd4: up = (sh > 0) && (rem >= half);
            default: up = (rem > half) || ((sh > 0) && (rem == half) && q[0]);
        endcase
        q = q + 64'(up);
        e = p;
        if (q == (64'd1 << prec)) begin
            q = q >> 1;
            e = e + 1;
        end
        nx = NX_ON && (rem != 0);
        if (fmt)
            r = {sign, 11'(e + 1023), q[51:0]};
        else
            r = {32'hFFFF_FFFF, sign, 8'(e + 127), q[22:0]};
        return {r, 4'b0, nx};
    endfunction

    function automatic logic [63:0] rmag();
        logic [63:0] m;
        m = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0: m = 64'd0;
            1: m = m >> $urandom_range(0, 63);
            2: m = (64'd1 << $urandom_range(0, 63)) | (64'd1 << $urandom_range(0, 63));
            3: m = m | 64'hFF_FFFF_FFFF;
            default: ;
        endcase
        return m;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Scoreboard: every accepted beat predicts one result, checked in order.
    logic [68:0] exp_e;
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (in_valid && in_ready)
                sb.push_back(model(in_mag, in_sign, in_fmt, in_rm));
            if (out_valid && out_ready) begin
                compared++;
                if (sb.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_output got=%h", out_result);
                end else begin
                    exp_e = sb.pop_front();
                    if ({out_result, out_fflags} !== exp_e) begin
                        mismatched++;
                        $display("FAIL sb_result got=%h/%b expected=%h/%b",
                                 out_result, out_fflags, exp_e[68:5], exp_e[4:0]);
                    end
                end
            end
        end
    end

    task automatic run_one(input string name, input logic [63:0] mag,
                           input logic sign, input logic fmt,
                           input logic [2:0] rm, input logic [63:0] lit,
                           input logic nx_lit);
        int k;
        logic [68:0] m;
        m = model(mag, sign, fmt, rm);
        chk({name, "_model"}, m[68:5], lit);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_mag = mag;
        in_sign = sign;
        in_fmt = fmt;
        in_rm = rm;
        @(negedge clk);
        chk({name, "_accept"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < 10);
        chk({name, "_latency"}, 64'(k), 64'd3);
        chk({name, "_result"}, out_result, lit);
        chk({name, "_nx"}, 64'(out_fflags), 64'(NX_ON && nx_lit));
    endtask

    logic [63:0] bp_mag [5];
    logic [15:0] ov;
    int          idx, accepts, sent, stale;
    logic        acc;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_mag = '0;
        in_sign = 1'b0;
        in_fmt = 1'b0;
        in_rm = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_result", out_result, 64'd0);
        chk("rst_out_fflags", 64'(out_fflags), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        run_one("d_one", 64'd1, 1'b0, 1'b1, 3'd0, 64'h3FF0_0000_0000_0000, 1'b0);
        run_one("s_ones", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 3'd0,
                64'hFFFF_FFFF_5F80_0000, 1'b1);
        run_one("d_tie_rne", 64'h0020_0000_0000_0001, 1'b0, 1'b1, 3'd0,
                64'h4340_0000_0000_0000, 1'b1);
        run_one("d_tie_rup", 64'h0020_0000_0000_0001, 1'b0, 1'b1, 3'd3,
                64'h4340_0000_0000_0001, 1'b1);
        run_one("d_tie_rdn", 64'h0020_0000_0000_0001, 1'b1, 1'b1, 3'd2,
                64'hC340_0000_0000_0001, 1'b1);
        run_one("d_zero", 64'd0, 1'b1, 1'b1, 3'd2, 64'h0, 1'b0);
        run_one("s_zero", 64'd0, 1'b1, 1'b0, 3'd4, 64'hFFFF_FFFF_0000_0000, 1'b0);

        // Backpressure: 5 beats against a stalled consumer, then drain.
        for (int i = 0; i < 5; i++)
            bp_mag[i] = rmag() | 64'd1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        idx = 0;
        accepts = 0;
        in_valid = 1'b1;
        in_mag = bp_mag[0];
        in_sign = 1'b0;
        in_fmt = 1'b1;
        in_rm = 3'd0;
        ov = '0;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (c >= 6)
                ov[c - 6] = out_valid;
            if (c == 5)
                chk("bp_in_ready_low", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
            if (acc) begin
                accepts++;
                idx++;
                if (idx < 5) begin
                    in_mag = bp_mag[idx];
                    in_fmt = idx[0];
                    in_rm = 3'(idx);
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (c == 5) begin
                chk("bp_accepts_stalled", 64'(accepts), 64'd3);
                out_ready = 1'b1;
            end
        end
        chk("bp_accepts_total", 64'(accepts), 64'd5);
        chk("bp_drain_rate", 64'(ov), 64'h001F);

        // Reset with two beats in flight.
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_mag = 64'd12345;
        in_fmt = 1'b1;
        @(posedge clk);
        #1;
        in_mag = 64'd777;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("post_rst_stale", 64'(stale), 64'd0);

        // Randomized traffic with random backpressure.
        sent = 0;
        for (int c = 0; c < 20000 && (sent < 600 || in_valid); c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc)
                in_valid = 1'b0;
            if (!in_valid && sent < 600 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_mag = rmag();
                in_sign = 1'($urandom);
                in_fmt = 1'($urandom);
                in_rm = 3'($urandom_range(0, 7));
                sent++;
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 50 && (sb.size() != 0 || out_valid); c++)
            @(negedge clk);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);
        chk("random_all_sent", 64'(sent), 64'd600);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
